// File: rtl/char_editor_scan_if.sv
// Bus between the button/control side and the character editor-scanner.
// The master drives the edit controls; the slave (editor) drives codes and scan outputs.
interface char_editor_scan_if #(
   parameter int unsigned NUM_DIGITS = 7,
   parameter int unsigned CODE_W     = 7,
   parameter int unsigned CUR_W      = $clog2(NUM_DIGITS)
);
   logic                           edit_en;
   logic                           left_pulse;
   logic                           right_pulse;
   logic                           inc_pulse;
   logic                           dec_pulse;
   logic                           load;
   logic [NUM_DIGITS*CODE_W-1:0]   load_codes;
   logic [NUM_DIGITS*CODE_W-1:0]   codes;
   logic [CUR_W-1:0]               cursor;
   logic                           dirty;
   logic [NUM_DIGITS-1:0]          digit_sel_n;
   logic [CODE_W-1:0]              scan_code;
   logic                           scan_blank;
   logic [NUM_DIGITS-1:0]          cursor_led_n;

   modport master (
      output edit_en, left_pulse, right_pulse, inc_pulse, dec_pulse, load, load_codes,
      input  codes, cursor, dirty, digit_sel_n, scan_code, scan_blank, cursor_led_n
   );

   modport slave (
      input  edit_en, left_pulse, right_pulse, inc_pulse, dec_pulse, load, load_codes,
      output codes, cursor, dirty, digit_sel_n, scan_code, scan_blank, cursor_led_n
   );
endinterface

// File: rtl/char_editor_scan.sv
// Editor for an N-digit character string driven by button pulses, plus the
// multiplexed digit scan with a blinking cursor digit/LED.
module char_editor_scan #(
   parameter int unsigned NUM_DIGITS = 7,
   parameter int unsigned CODE_W     = 7,
   parameter int unsigned MAX_CODE   = 62,
   parameter int unsigned SCAN_DIV   = 25000,
   parameter int unsigned BLINK_DIV  = 12500000,
   parameter int unsigned CUR_W      = $clog2(NUM_DIGITS)
) (
   input logic              clk,
   input logic              rst,
   char_editor_scan_if.slave bus
);
   localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CODE_W-1:0]  MAX_C      = CODE_W'(MAX_CODE);
   localparam logic [CUR_W-1:0]   LAST_DIG   = CUR_W'(NUM_DIGITS - 1);
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [CODE_W-1:0]  codes_q [NUM_DIGITS];
   logic [CODE_W-1:0]  codes_d [NUM_DIGITS];
   logic [CUR_W-1:0]   cursor_q, cursor_d;
   logic               dirty_q, dirty_d;
   logic [CUR_W-1:0]   scan_idx_q, scan_idx_d;
   logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_off_q, blink_off_d;

   logic               move;
   logic               edit;
   logic [CODE_W-1:0]  cur_code;
   logic [CODE_W-1:0]  fld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) codes_q[i] <= '0;
         cursor_q    <= '0;
         dirty_q     <= 1'b0;
         scan_idx_q  <= '0;
         scan_cnt_q  <= '0;
         blink_cnt_q <= '0;
         blink_off_q <= 1'b0;
      end else begin
         codes_q     <= codes_d;
         cursor_q    <= cursor_d;
         dirty_q     <= dirty_d;
         scan_idx_q  <= scan_idx_d;
         scan_cnt_q  <= scan_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_off_q <= blink_off_d;
      end
   end

   always_comb begin
      codes_d     = codes_q;
      cursor_d    = cursor_q;
      dirty_d     = dirty_q;
      scan_idx_d  = scan_idx_q;
      scan_cnt_d  = scan_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_off_d = blink_off_q;
      fld         = '0;
      move        = bus.left_pulse ^ bus.right_pulse;
      edit        = bus.inc_pulse ^ bus.dec_pulse;
      cur_code    = codes_q[cursor_q];

      // Scan runs unconditionally
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == LAST_DIG) ? '0 : scan_idx_q + CUR_W'(1);
      end else begin
         scan_cnt_d = scan_cnt_q + SCAN_W'(1);
      end

      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_off_d = ~blink_off_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end

      if (bus.load) begin
         // Out-of-range fields load as code 0; blink keeps its phase
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            fld        = bus.load_codes[i*CODE_W +: CODE_W];
            codes_d[i] = (fld > MAX_C) ? '0 : fld;
         end
         cursor_d = '0;
         dirty_d  = 1'b0;
         if (!bus.edit_en) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
         end
      end else if (!bus.edit_en) begin
         cursor_d    = '0;
         blink_cnt_d = '0;
         blink_off_d = 1'b0;
      end else begin
         if (edit) begin
            if (bus.inc_pulse) codes_d[cursor_q] = (cur_code == MAX_C) ? '0 : cur_code + CODE_W'(1);
            else               codes_d[cursor_q] = (cur_code == '0) ? MAX_C : cur_code - CODE_W'(1);
            dirty_d = 1'b1;
         end
         if (move) begin
            if (bus.left_pulse) cursor_d = (cursor_q == '0) ? LAST_DIG : cursor_q - CUR_W'(1);
            else                cursor_d = (cursor_q == LAST_DIG) ? '0 : cursor_q + CUR_W'(1);
         end
         // Any accepted event makes the cursor visible at once
         if (edit || move) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
      assign bus.codes[g*CODE_W +: CODE_W] = codes_q[g];
   end

   assign bus.cursor       = cursor_q;
   assign bus.dirty        = dirty_q;
   assign bus.digit_sel_n  = ~(NUM_DIGITS'(1) << scan_idx_q);
   assign bus.scan_code    = codes_q[scan_idx_q];
   assign bus.scan_blank   = bus.edit_en && blink_off_q && (scan_idx_q == cursor_q);
   assign bus.cursor_led_n = (bus.edit_en && !blink_off_q) ? ~(NUM_DIGITS'(1) << cursor_q) : '1;
endmodule

// File: tb/tb_char_editor_scan.sv
// Bench for char_editor_scan: directed table, corner sequences and random
// stimulus against a cycle-count based reference model.
module tb_char_editor_scan;
   localparam int unsigned ND    = 7;
   localparam int unsigned CW    = 7;
   localparam int unsigned MAXC  = 62;
   localparam int unsigned SDIV  = 4;
   localparam int unsigned BDIV  = 8;
   localparam int unsigned CURW  = $clog2(ND);
   localparam int unsigned PW    = ND * CW;

   typedef struct {
      logic ee, l, r, i, d, ld;
      logic [PW-1:0] lc;
      int exp_cur;
      int probe;
      int exp_val;
      int exp_dirty;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks;
   int   errors;

   int m_codes [ND];
   int m_cur, m_dirty, m_tick, m_bcnt;

   vec_t tbl [13];

   always #5 clk = ~clk;

   char_editor_scan_if #(.NUM_DIGITS(ND), .CODE_W(CW), .CUR_W(CURW)) bus ();

   char_editor_scan #(
      .NUM_DIGITS(ND), .CODE_W(CW), .MAX_CODE(MAXC),
      .SCAN_DIV(SDIV), .BLINK_DIV(BDIV), .CUR_W(CURW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < ND; k++) m_codes[k] = 0;
      m_cur = 0; m_dirty = 0; m_tick = 0; m_bcnt = 0;
   endtask

   task automatic model_step();
      int f;
      bit ev;
      m_tick++;
      if (bus.load) begin
         for (int k = 0; k < ND; k++) begin
            f = int'(bus.load_codes[k*CW +: CW]);
            m_codes[k] = (f > int'(MAXC)) ? 0 : f;
         end
         m_cur = 0; m_dirty = 0;
         m_bcnt = bus.edit_en ? m_bcnt + 1 : 0;
      end else if (!bus.edit_en) begin
         m_cur = 0; m_bcnt = 0;
      end else begin
         m_bcnt++;
         ev = 1'b0;
         if (bus.inc_pulse != bus.dec_pulse) begin
            if (bus.inc_pulse) m_codes[m_cur] = (m_codes[m_cur] + 1) % (int'(MAXC) + 1);
            else               m_codes[m_cur] = (m_codes[m_cur] + int'(MAXC)) % (int'(MAXC) + 1);
            m_dirty = 1; ev = 1'b1;
         end
         if (bus.left_pulse != bus.right_pulse) begin
            m_cur = bus.left_pulse ? (m_cur + ND - 1) % ND : (m_cur + 1) % ND;
            ev = 1'b1;
         end
         if (ev) m_bcnt = 0;
      end
   endtask

   task automatic check_all();
      logic [PW-1:0] ec;
      logic [ND-1:0] es, el;
      int sidx;
      bit boff;
      for (int k = 0; k < ND; k++) ec[k*CW +: CW] = CW'(m_codes[k]);
      sidx = (m_tick / SDIV) % ND;
      boff = bus.edit_en && (((m_bcnt / BDIV) % 2) == 1);
      es = '1; es[sidx] = 1'b0;
      el = '1;
      if (bus.edit_en && !boff) el[m_cur] = 1'b0;
      chk("codes",        64'(bus.codes),        64'(ec));
      chk("cursor",       64'(bus.cursor),       64'(m_cur));
      chk("dirty",        64'(bus.dirty),        64'(m_dirty));
      chk("digit_sel_n",  64'(bus.digit_sel_n),  64'(es));
      chk("scan_code",    64'(bus.scan_code),    64'(m_codes[sidx]));
      chk("scan_blank",   64'(bus.scan_blank),   64'(boff && (sidx == m_cur)));
      chk("cursor_led_n", 64'(bus.cursor_led_n), 64'(el));
   endtask

   task automatic cyc(input logic ee, l, r, i, d, ld, input logic [PW-1:0] lc);
      bus.edit_en = ee; bus.left_pulse = l; bus.right_pulse = r;
      bus.inc_pulse = i; bus.dec_pulse = d; bus.load = ld; bus.load_codes = lc;
      @(posedge clk);
      model_step();
      #1;
      check_all();
      bus.left_pulse = 1'b0; bus.right_pulse = 1'b0; bus.inc_pulse = 1'b0;
      bus.dec_pulse = 1'b0; bus.load = 1'b0;
   endtask

   task automatic run_row(input int n);
      cyc(tbl[n].ee, tbl[n].l, tbl[n].r, tbl[n].i, tbl[n].d, tbl[n].ld, tbl[n].lc);
      chk($sformatf("tbl%0d_cursor", n), 64'(bus.cursor), 64'(tbl[n].exp_cur));
      chk($sformatf("tbl%0d_code", n), 64'(bus.codes[tbl[n].probe*CW +: CW]), 64'(tbl[n].exp_val));
      chk($sformatf("tbl%0d_dirty", n), 64'(bus.dirty), 64'(tbl[n].exp_dirty));
   endtask

   initial begin
      logic [PW-1:0] lc;
      logic [ND-1:0] es;
      int dens;
      checks = 0; errors = 0;

      //                ee  l     r     i     d     ld    lc                        cur prb val drt
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0,                        6, 2, 0,  0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,                        0, 2, 0,  0};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0,                        0, 2, 0,  0};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,                        1, 2, 0,  0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,                        2, 2, 0,  0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0,                        2, 2, 62, 1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0,                        2, 2, 0,  1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (PW'(5) << 21) | PW'(10), 0, 3, 5,  0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,                        1, 3, 5,  0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,                        2, 3, 5,  0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,                        3, 3, 5,  0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0,                        4, 3, 6,  1};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, PW'(70) << 21,             0, 3, 0,  0};

      rst = 1'b0;
      bus.edit_en = 1'b0; bus.left_pulse = 1'b0; bus.right_pulse = 1'b0;
      bus.inc_pulse = 1'b0; bus.dec_pulse = 1'b0; bus.load = 1'b0; bus.load_codes = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_codes",  64'(bus.codes),        64'd0);
      chk("rst_cursor", 64'(bus.cursor),       64'd0);
      chk("rst_dirty",  64'(bus.dirty),        64'd0);
      chk("rst_sel",    64'(bus.digit_sel_n),  64'h7E);
      chk("rst_scode",  64'(bus.scan_code),    64'd0);
      chk("rst_blank",  64'(bus.scan_blank),   64'd0);
      chk("rst_led",    64'(bus.cursor_led_n), 64'h7F);
      rst = 1'b1;

      // Scan walk: one digit per SDIV cycles, wraps after ND digits
      for (int k = 1; k <= 28; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
         es = '1; es[(k / SDIV) % ND] = 1'b0;
         chk("scan_walk_sel", 64'(bus.digit_sel_n), 64'(es));
         chk("scan_walk_code", 64'(bus.scan_code), 64'd0);
      end
      chk("scan_wrap", 64'(bus.digit_sel_n), 64'h7E);

      for (int n = 0; n <= 6; n++) run_row(n);
      for (int k = 0; k < 63; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("inc63_code2", 64'(bus.codes[2*CW +: CW]), 64'd0);
      for (int n = 7; n <= 12; n++) run_row(n);

      // Blink: restart, go dark after BDIV cycles, edit relights and restarts
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      repeat (8) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("blink_dark_led", 64'(bus.cursor_led_n), 64'h7F);
      chk("blink_dark_blank", 64'(bus.scan_blank), 64'(((m_tick / SDIV) % ND) == 0));
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("blink_relit_led", 64'(bus.cursor_led_n), 64'h7E);
      chk("blink_relit_blank", 64'(bus.scan_blank), 64'd0);
      repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("blink_restart_lit", 64'(bus.cursor_led_n), 64'h7E);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      chk("blink_restart_dark", 64'(bus.cursor_led_n), 64'h7F);

      // Random traffic, dense then sparse pulses
      for (int k = 0; k < 600; k++) begin
         dens = (k < 300) ? 3 : 15;
         for (int f = 0; f < ND; f++) lc[f*CW +: CW] = CW'($urandom_range(0, 127));
         cyc($urandom_range(0, 15) != 0,
             $urandom_range(0, dens) == 0, $urandom_range(0, dens) == 0,
             $urandom_range(0, dens) == 0, $urandom_range(0, dens) == 0,
             $urandom_range(0, 31) == 0, lc);
      end

      // Async reset mid-scan and mid-edit
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("pre_rst_cursor", 64'(bus.cursor), 64'd5);
      chk("pre_rst_dirty", 64'(bus.dirty), 64'd1);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      chk("arst_codes",  64'(bus.codes),       64'd0);
      chk("arst_cursor", 64'(bus.cursor),      64'd0);
      chk("arst_dirty",  64'(bus.dirty),       64'd0);
      chk("arst_sel",    64'(bus.digit_sel_n), 64'h7E);
      chk("arst_scode",  64'(bus.scan_code),   64'd0);
      chk("arst_blank",  64'(bus.scan_blank),  64'd0);
      bus.edit_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Edit disabled: pulses ignored, cursor held at 0, LEDs off, scan continues
      for (int k = 0; k < 14; k++) begin
         cyc(1'b0, k[0], k[1], k[0], ~k[0], 1'b0, '0);
         chk("noedit_cursor", 64'(bus.cursor), 64'd0);
         chk("noedit_led", 64'(bus.cursor_led_n), 64'h7F);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/char_editor_scan.md
Name: char_editor_scan

Overview:
- Parametrised editor and display scanner for an N-digit 7-segment character string.
- Holds one character code per digit and edits them from debounced button pulses: cursor left/right, code increment/decrement.
- Time-multiplexes the digits, blinking the digit under the cursor and its cursor LED.
- Sits between the button debouncers and the character lookup table; the top level feeds scan_code into the table to produce segments.

Parameters:
- NUM_DIGITS, 7, number of digits/characters (>=2).
- CODE_W, 7, width of one character code.
- MAX_CODE, 62, highest legal code; codes range 0..MAX_CODE.
- SCAN_DIV, 25000, clock cycles per digit in the scan.
- BLINK_DIV, 12500000, clock cycles per blink half-period.
- CUR_W, $clog2(NUM_DIGITS), cursor/scan index width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- edit_en  in  1  edit mode enable
- left_pulse  in  1  one-cycle pulse: cursor left
- right_pulse  in  1  one-cycle pulse: cursor right
- inc_pulse  in  1  one-cycle pulse: increment code at cursor
- dec_pulse  in  1  one-cycle pulse: decrement code at cursor
- load  in  1  one-cycle pulse: load all codes from load_codes
- load_codes  in  NUM_DIGITS*CODE_W  packed codes; digit i at [i*CODE_W +: CODE_W]
- codes  out  NUM_DIGITS*CODE_W  packed current codes, same packing
- cursor  out  CUR_W  current cursor position
- dirty  out  1  set when any code has been edited since reset/load
- digit_sel_n  out  NUM_DIGITS  active-low one-hot digit enable
- scan_code  out  CODE_W  code of currently scanned digit
- scan_blank  out  1  scanned digit must be blanked (all segments off)
- cursor_led_n  out  NUM_DIGITS  active-low one-hot cursor indicator

Behaviour:
- Reset (rst=0, async): all codes 0, cursor 0, dirty 0, scan_idx 0, scan_cnt 0, blink_cnt 0, blink_off 0. digit_sel_n = ~1 (digit 0 on). scan_code 0, scan_blank 0. cursor_led_n all ones.
- Scan always runs, regardless of edit_en:
  - scan_cnt counts 0..SCAN_DIV-1. At terminal it resets to 0 and scan_idx advances, wrapping NUM_DIGITS-1 -> 0.
  - digit_sel_n = ~(1<<scan_idx) and scan_code = codes[scan_idx], both decoded from registers with no added latency.
- Blink, when edit_en=1:
  - blink_cnt counts 0..BLINK_DIV-1; at terminal it resets and blink_off toggles.
  - scan_blank = blink_off && scan_idx==cursor.
  - cursor_led_n = blink_off ? all ones : ~(1<<cursor).
- Any accepted edit or move event sets blink_cnt to 0 and blink_off to 0, so the cursor is immediately visible.
- edit_en=0: cursor forced 0, blink_cnt 0, blink_off 0, scan_blank 0, cursor_led_n all ones. All pulses ignored except load.
- Cursor moves (edit_en=1):
  - left: 0 wraps to NUM_DIGITS-1, else -1.
  - right: NUM_DIGITS-1 wraps to 0, else +1.
  - left and right in the same cycle: no move, no blink restart.
- Code edits (edit_en=1), applied to codes[cursor]:
  - inc: MAX_CODE wraps to 0, else +1.
  - dec: 0 wraps to MAX_CODE, else -1.
  - inc and dec in the same cycle: no change.
  - Any effective edit sets dirty=1.
- Edit and move in the same cycle: the edit applies at the pre-move cursor; the move takes effect in the same cycle (both visible next cycle).
- load (highest priority):
  - Each codes[i] = load_codes field, or 0 if the field > MAX_CODE.
  - cursor 0, dirty 0. All other pulses that cycle are ignored.
  - Blink state is not restarted; scan is not disturbed.
- Held pulses (input high for multiple cycles) act once per cycle high; the upstream debouncer guarantees single-cycle pulses.
- All arithmetic is CODE_W / CUR_W wide with explicit wrap compares; no reliance on natural overflow.

Test Plan:
- Reset with SCAN_DIV=4, NUM_DIGITS=7, then run 28 cycles -> digit_sel_n steps 1111110, 1111101, … 0111111, one digit every 4 cycles, then returns to 1111110; scan_code = 0 throughout.
- edit_en=1, cursor 0: one left_pulse -> cursor=6. Then one right_pulse -> cursor=0. left_pulse and right_pulse together -> cursor unchanged.
- cursor 2: dec_pulse -> codes[2]=62, dirty=1. Then inc_pulse -> codes[2]=0. Then 63 inc_pulses -> codes[2]=0.
- BLINK_DIV=8: after 8 cycles blink_off=1 -> cursor_led_n all ones and scan_blank=1 only while scan_idx==cursor. An inc_pulse during blink_off -> blink_off=0 next cycle and counter restarts.
- inc_pulse and right_pulse together at cursor 3, codes[3]=5 -> codes[3]=6, cursor=4. load with field 3 = 70 and right_pulse together -> codes[3]=0, cursor=0, dirty=0.
- Assert rst mid-scan and mid-edit (cursor 5, dirty=1) -> all state returns to reset values immediately, asynchronously to clk. edit_en=0 -> cursor 0, cursor_led_n all ones, scanning continues.
